// File: rtl/counter_wrap_monitor_pkg.sv
// Shared definitions for the counter wrap monitor: FSM states, overflow timing modes, default widths.
package counter_mon_pkg;

    localparam int unsigned CNT_W_DEF   = 4;
    localparam int unsigned EPOCH_W_DEF = 8;
    localparam int unsigned ERRC_W_DEF  = 8;

    localparam int unsigned OVF_AT_MAX     = 0;
    localparam int unsigned OVF_AFTER_WRAP = 1;

    typedef enum logic [1:0] {
        MON_IDLE   = 2'd0,
        MON_TRACK  = 2'd1,
        MON_RESYNC = 2'd2
    } mon_state_t;

    // Two independent fault pulses in one sample each count once.
    function automatic logic [1:0] err_inc(input logic seq_fault, input logic ovf_fault);
        return {1'b0, seq_fault} + {1'b0, ovf_fault};
    endfunction

endpackage

// File: rtl/counter_wrap_monitor_if.sv
// Observation bus from the 4-bit up-counter (and its control inputs) into the wrap monitor.
interface counter_wrap_monitor_if
    import counter_mon_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
);
    logic             cnt_reset;
    logic             enable;
    logic [CNT_W-1:0] counter_in;
    logic             overflow_in;

    modport master (output cnt_reset, enable, counter_in, overflow_in);
    modport slave  (input  cnt_reset, enable, counter_in, overflow_in);
endinterface

// File: rtl/counter_wrap_monitor_sat_counter.sv
// Saturating up-counter with 0/1/2 increment and synchronous clear; used for the error tally.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic [1:0]   inc,
    output logic [W-1:0] count
);

    logic [W:0] sum;

    assign sum = {1'b0, count} + {{(W-1){1'b0}}, inc};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (sum[W]) begin
            count <= '1;
        end else begin
            count <= sum[W-1:0];
        end
    end

endmodule

// File: rtl/counter_wrap_monitor.sv
// Step checker for the enable-gated up-counter: epoch tracking, fault pulses, sticky flag, error tally.
// Optional fault capture registers are built when COUNTER_WRAP_MONITOR_CAPTURE_EN is defined.
module counter_wrap_monitor
    import counter_mon_pkg::*;
#(
    parameter int unsigned CNT_W    = CNT_W_DEF,
    parameter int unsigned EPOCH_W  = EPOCH_W_DEF,
    parameter int unsigned ERRC_W   = ERRC_W_DEF,
    parameter int unsigned OVF_MODE = OVF_AT_MAX
) (
    input  logic                   clk,
    input  logic                   reset,
    counter_wrap_monitor_if.slave  mon,
    input  logic                   clear,
    output logic [EPOCH_W-1:0]     epoch_out,
    output logic                   wrap_pulse,
    output logic                   err_seq,
    output logic                   err_ovf,
    output logic                   err_sticky,
    output logic [ERRC_W-1:0]      err_count,
    output logic [1:0]             state_out,
    output logic [CNT_W-1:0]       cap_expected,
    output logic [CNT_W-1:0]       cap_observed
);

    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]   CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [EPOCH_W-1:0] EPOCH_ONE = {{(EPOCH_W-1){1'b0}}, 1'b1};

    mon_state_t       state;
    logic [CNT_W-1:0] prev_cnt;
    logic             prev_en;
    logic             just_wrapped;

    logic             checking;
    logic [CNT_W-1:0] exp_cnt;
    logic             exp_ovf;
    logic             seq_fault;
    logic             ovf_fault;
    logic             wrap_hit;
    logic [1:0]       err_step;

    // Faults are decided combinationally from the current sample so that the
    // pulses and the error tally both land on the same edge.
    always_comb begin
        checking = (state == MON_TRACK) && !mon.cnt_reset;
        exp_cnt  = prev_en ? (prev_cnt + CNT_ONE) : prev_cnt;
        if (OVF_MODE == OVF_AFTER_WRAP) begin
            exp_ovf = just_wrapped;
        end else begin
            exp_ovf = (mon.counter_in == CNT_MAX);
        end
        seq_fault = checking && (mon.counter_in != exp_cnt);
        ovf_fault = checking && (mon.overflow_in != exp_ovf);
        wrap_hit  = checking && prev_en && (prev_cnt == CNT_MAX) && (mon.counter_in == '0);
        err_step  = err_inc(seq_fault, ovf_fault);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= MON_IDLE;
            prev_cnt     <= '0;
            prev_en      <= 1'b0;
            just_wrapped <= 1'b0;
            wrap_pulse   <= 1'b0;
            err_seq      <= 1'b0;
            err_ovf      <= 1'b0;
            err_sticky   <= 1'b0;
            epoch_out    <= '0;
        end else begin
            wrap_pulse <= wrap_hit;
            err_seq    <= seq_fault;
            err_ovf    <= ovf_fault;

            if (clear) begin
                epoch_out  <= '0;
                err_sticky <= 1'b0;
            end else begin
                if (wrap_hit) begin
                    epoch_out <= epoch_out + EPOCH_ONE;
                end
                if (seq_fault || ovf_fault) begin
                    err_sticky <= 1'b1;
                end
            end

            if (mon.cnt_reset) begin
                state        <= MON_IDLE;
                just_wrapped <= 1'b0;
            end else begin
                case (state)
                    MON_IDLE, MON_RESYNC: begin
                        state        <= MON_TRACK;
                        prev_cnt     <= mon.counter_in;
                        prev_en      <= mon.enable;
                        just_wrapped <= 1'b0;
                    end
                    MON_TRACK: begin
                        state        <= seq_fault ? MON_RESYNC : MON_TRACK;
                        prev_cnt     <= mon.counter_in;
                        prev_en      <= mon.enable;
                        just_wrapped <= wrap_hit;
                    end
                    default: begin
                        state <= MON_IDLE;
                    end
                endcase
            end
        end
    end

    assign state_out = state;

    sat_counter #(
        .W (ERRC_W)
    ) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .inc   (err_step),
        .count (err_count)
    );

`ifdef COUNTER_WRAP_MONITOR_CAPTURE_EN
    logic cap_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_done     <= 1'b0;
            cap_expected <= '0;
            cap_observed <= '0;
        end else if (clear) begin
            cap_done     <= 1'b0;
            cap_expected <= '0;
            cap_observed <= '0;
        end else if (seq_fault && !cap_done) begin
            cap_done     <= 1'b1;
            cap_expected <= exp_cnt;
            cap_observed <= mon.counter_in;
        end
    end
`else
    assign cap_expected = '0;
    assign cap_observed = '0;
`endif

endmodule

// File: tb/tb_counter_wrap_monitor.sv
// Directed bench for counter_wrap_monitor with a per-cycle reference model and literal spot checks.
module tb_counter_wrap_monitor;
    import counter_mon_pkg::*;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       clear = 1'b0;
    logic [7:0] epoch_out;
    logic       wrap_pulse;
    logic       err_seq;
    logic       err_ovf;
    logic       err_sticky;
    logic [7:0] err_count;
    logic [1:0] state_out;
    logic [3:0] cap_expected;
    logic [3:0] cap_observed;

    counter_wrap_monitor_if #(.CNT_W(4)) mon_if ();

    counter_wrap_monitor #(
        .CNT_W    (4),
        .EPOCH_W  (8),
        .ERRC_W   (8),
        .OVF_MODE (0)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .mon          (mon_if),
        .clear        (clear),
        .epoch_out    (epoch_out),
        .wrap_pulse   (wrap_pulse),
        .err_seq      (err_seq),
        .err_ovf      (err_ovf),
        .err_sticky   (err_sticky),
        .err_count    (err_count),
        .state_out    (state_out),
        .cap_expected (cap_expected),
        .cap_observed (cap_observed)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    bit checking = 1'b0;
    int cnt_drv = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: 0 = not synced, 1 = comparing steps, 2 = skip one sample.
    int m_phase, m_pc, m_epoch, m_errs, m_cap_e, m_cap_o, m_want;
    bit m_pe, m_sticky, m_wrap, m_seq, m_ovf, m_cap_done;
    bit sq, ov, wr;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase = 0; m_pc = 0; m_pe = 0; m_epoch = 0; m_errs = 0;
            m_sticky = 0; m_wrap = 0; m_seq = 0; m_ovf = 0;
            m_cap_e = 0; m_cap_o = 0; m_cap_done = 0;
        end else begin
            sq = 0; ov = 0; wr = 0;
            if (mon_if.cnt_reset) begin
                m_phase = 0;
            end else if (m_phase == 1) begin
                m_want = m_pe ? (m_pc + 1) % 16 : m_pc;
                sq = (int'(mon_if.counter_in) != m_want);
                ov = (mon_if.overflow_in != (mon_if.counter_in == 4'd15));
                wr = m_pe && (m_pc == 15) && (mon_if.counter_in == 4'd0);
                m_pc = int'(mon_if.counter_in);
                m_pe = mon_if.enable;
                m_phase = sq ? 2 : 1;
            end else begin
                m_pc = int'(mon_if.counter_in);
                m_pe = mon_if.enable;
                m_phase = 1;
            end
            m_seq = sq; m_ovf = ov; m_wrap = wr;
            if (clear) begin
                m_errs = 0; m_sticky = 0; m_epoch = 0;
                m_cap_e = 0; m_cap_o = 0; m_cap_done = 0;
            end else begin
                m_errs = m_errs + int'(sq) + int'(ov);
                if (m_errs > 255) m_errs = 255;
                m_sticky = m_sticky | sq | ov;
                m_epoch = (m_epoch + int'(wr)) % 256;
                if (sq && !m_cap_done) begin
                    m_cap_e = m_want;
                    m_cap_o = int'(mon_if.counter_in);
                    m_cap_done = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("state_out",  int'(state_out),  m_phase);
            chk("epoch_out",  int'(epoch_out),  m_epoch);
            chk("wrap_pulse", int'(wrap_pulse), int'(m_wrap));
            chk("err_seq",    int'(err_seq),    int'(m_seq));
            chk("err_ovf",    int'(err_ovf),    int'(m_ovf));
            chk("err_sticky", int'(err_sticky), int'(m_sticky));
            chk("err_count",  int'(err_count),  m_errs);
`ifdef COUNTER_WRAP_MONITOR_CAPTURE_EN
            chk("cap_expected", int'(cap_expected), m_cap_e);
            chk("cap_observed", int'(cap_observed), m_cap_o);
`else
            chk("cap_expected", int'(cap_expected), 0);
            chk("cap_observed", int'(cap_observed), 0);
`endif
        end
    end

    task automatic step(input bit cr, input bit en, input int cnt, input bit ovf, input bit clr);
        @(negedge clk);
        #1;
        mon_if.cnt_reset   = cr;
        mon_if.enable      = en;
        mon_if.counter_in  = 4'(cnt);
        mon_if.overflow_in = ovf;
        clear              = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b1, cnt_drv, cnt_drv == 15, 1'b0);
            cnt_drv = (cnt_drv + 1) % 16;
        end
    endtask

    initial begin
        mon_if.cnt_reset   = 1'b1;
        mon_if.enable      = 1'b0;
        mon_if.counter_in  = 4'd0;
        mon_if.overflow_in = 1'b0;
        #12;
        chk("rst_state",  int'(state_out),  0);
        chk("rst_epoch",  int'(epoch_out),  0);
        chk("rst_count",  int'(err_count),  0);
        chk("rst_sticky", int'(err_sticky), 0);
        chk("rst_pulses", int'({wrap_pulse, err_seq, err_ovf}), 0);
        @(negedge clk);
        reset = 1'b0;
        checking = 1'b1;

        // Legal run: 40 samples 0..15,0..15,0..7 -> two wraps.
        step(1'b1, 1'b0, 0, 1'b0, 1'b0);
        cnt_drv = 0;
        run(40);
        chk("t1_epoch",  int'(epoch_out),  2);
        chk("t1_count",  int'(err_count),  0);
        chk("t1_sticky", int'(err_sticky), 0);
        chk("t1_state",  int'(state_out),  1);

        // Stuck at 7 with enable high.
        run(16);
        chk("t2_epoch", int'(epoch_out), 3);
        step(1'b0, 1'b1, 7, 1'b0, 1'b0);
        chk("t2_seq",   int'(err_seq),   1);
        chk("t2_ovf",   int'(err_ovf),   0);
        chk("t2_state", int'(state_out), 2);
        chk("t2_count", int'(err_count), 1);
        run(1);
        chk("t2_resync_state", int'(state_out), 1);
        chk("t2_resync_seq",   int'(err_seq),   0);
        run(1);
        chk("t2_legal_seq",   int'(err_seq),   0);
        chk("t2_legal_count", int'(err_count), 1);

        // Overflow missing at 15.
        run(5);
        step(1'b0, 1'b1, 15, 1'b0, 1'b0);
        chk("t3_ovf",   int'(err_ovf),   1);
        chk("t3_seq",   int'(err_seq),   0);
        chk("t3_count", int'(err_count), 2);
        cnt_drv = 0;
        run(1);
        chk("t3_wrap",  int'(wrap_pulse), 1);
        chk("t3_epoch", int'(epoch_out),  4);

        // 14 -> 0 jump with overflow asserted in the same sample.
        run(14);
        step(1'b0, 1'b1, 0, 1'b1, 1'b0);
        chk("t4_seq",   int'(err_seq),   1);
        chk("t4_ovf",   int'(err_ovf),   1);
        chk("t4_count", int'(err_count), 4);
        for (int i = 0; i < 130; i++) begin
            step(1'b0, 1'b1, 0, 1'b0, 1'b0);
            step(1'b0, 1'b1, 0, 1'b1, 1'b0);
        end
        chk("t4_sat",    int'(err_count),  255);
        chk("t4_sticky", int'(err_sticky), 1);

        // cnt_reset mid-count.
        step(1'b0, 1'b1, 0, 1'b0, 1'b0);
        cnt_drv = 1;
        run(25);
        step(1'b1, 1'b1, 10, 1'b0, 1'b0);
        chk("t5_state", int'(state_out), 0);
        chk("t5_seq",   int'(err_seq),   0);
        chk("t5_ovf",   int'(err_ovf),   0);
        chk("t5_epoch", int'(epoch_out), 5);
        chk("t5_count", int'(err_count), 255);
        step(1'b0, 1'b1, 0, 1'b0, 1'b0);
        chk("t5_track", int'(state_out), 1);
        cnt_drv = 1;
        run(3);
        // Clear together with a step error (3 repeated, 4 expected).
        step(1'b0, 1'b1, 3, 1'b0, 1'b1);
        chk("t5_clr_seq",    int'(err_seq),    1);
        chk("t5_clr_count",  int'(err_count),  0);
        chk("t5_clr_sticky", int'(err_sticky), 0);
        chk("t5_clr_epoch",  int'(epoch_out),  0);
        chk("t5_clr_state",  int'(state_out),  2);

        // Capture: 3 -> 5, then 6 -> 9, then clear.
        step(1'b0, 1'b1, 3, 1'b0, 1'b0);
        step(1'b0, 1'b1, 5, 1'b0, 1'b0);
        chk("t6_count", int'(err_count), 1);
`ifdef COUNTER_WRAP_MONITOR_CAPTURE_EN
        chk("t6_cap_e1", int'(cap_expected), 4);
        chk("t6_cap_o1", int'(cap_observed), 5);
`else
        chk("t6_cap_e1", int'(cap_expected), 0);
        chk("t6_cap_o1", int'(cap_observed), 0);
`endif
        step(1'b0, 1'b1, 6, 1'b0, 1'b0);
        step(1'b0, 1'b1, 9, 1'b0, 1'b0);
        chk("t6_count2", int'(err_count), 2);
`ifdef COUNTER_WRAP_MONITOR_CAPTURE_EN
        chk("t6_cap_e2", int'(cap_expected), 4);
        chk("t6_cap_o2", int'(cap_observed), 5);
`else
        chk("t6_cap_e2", int'(cap_expected), 0);
        chk("t6_cap_o2", int'(cap_observed), 0);
`endif
        step(1'b0, 1'b1, 10, 1'b0, 1'b1);
        chk("t6_cap_e3", int'(cap_expected), 0);
        chk("t6_cap_o3", int'(cap_observed), 0);
        chk("t6_count3", int'(err_count),    0);

        cnt_drv = 11;
        run(3);
        @(negedge clk);
        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/counter_wrap_monitor.md
Name: counter_wrap_monitor

Overview:
- Downstream checker/consumer of the 4-bit enable-gated up-counter (first_counter).
- Samples the counter's count and overflow outputs every clock and checks that each step is legal.
- Extends the count with a wider epoch (wrap) counter and reports sequence and overflow faults through pulse flags, a sticky flag and a saturating error counter.
- Sits beside the counter in self-checking benches and in-system health logic; it never drives the counter.

Parameters:
- CNT_W, 4, width of the observed count.
- EPOCH_W, 8, width of the wrap counter; wraps modulo 2^EPOCH_W.
- ERRC_W, 8, width of the error counter; saturates at all-ones.
- OVF_MODE, 0, overflow timing. 0: overflow_in is required high exactly in the cycle counter_in == all-ones. 1: overflow_in is required high exactly in the cycle after a wrap (counter_in == 0 following all-ones).

Ports:
- clk, in, 1, single clock, rising edge.
- reset, in, 1, asynchronous, active-high monitor reset.
- cnt_reset, in, 1, the reset currently applied to the counter; the monitor resynchronises while it is high.
- enable, in, 1, the enable currently applied to the counter.
- counter_in, in, CNT_W, the counter's counter_out.
- overflow_in, in, 1, the counter's overflow_out.
- clear, in, 1, synchronous clear of sticky flag, error count and epoch.
- epoch_out, out, EPOCH_W, number of observed legal wraps.
- wrap_pulse, out, 1, one-cycle pulse per legal wrap.
- err_seq, out, 1, one-cycle pulse: count step illegal.
- err_ovf, out, 1, one-cycle pulse: overflow_in mismatch.
- err_sticky, out, 1, set by any error, held until clear or reset.
- err_count, out, ERRC_W, errors seen, saturating.
- state_out, out, 2, FSM state: 0 IDLE, 1 TRACK, 2 RESYNC.

Behaviour:
- Reset (async, active-high): all outputs 0, state IDLE, internal prev_cnt = 0, prev_en = 0.
- All checks use values sampled at the rising edge. Flags are registered: a fault in sample k is visible on the outputs in the cycle after edge k.

FSM:
- IDLE: no checks. Go to TRACK on a sample with cnt_reset = 0; latch prev_cnt = counter_in and prev_en = enable.
- TRACK:
  - exp_cnt = prev_en ? (prev_cnt + 1) mod 2^CNT_W : prev_cnt.
  - counter_in != exp_cnt -> err_seq pulse, go to RESYNC.
  - exp_ovf per OVF_MODE, evaluated independently of the count check; mismatch -> err_ovf pulse, stay in TRACK.
  - Legal wrap (prev_en = 1, prev_cnt = all-ones, counter_in = 0) -> wrap_pulse and epoch_out + 1.
  - prev_cnt and prev_en update every cycle.
- RESYNC: no checks; relatch prev_cnt/prev_en from the current sample and return to TRACK next cycle.
- cnt_reset = 1 in any state -> IDLE next cycle. No error is raised for the count drop to 0; epoch is unchanged.

Error reporting:
- err_seq and err_ovf in the same sample: both pulse, err_count increments by 2, saturating. Each pulse counts once.
- err_sticky = OR of all pulses since the last clear.

Clear:
- clear has priority over increments in the same cycle: the result is 0, and a same-cycle error is dropped from the count and from the sticky flag.
- clear does not change the FSM state.

Arithmetic:
- epoch_out wraps all-ones -> 0 silently.
- err_count holds at all-ones.
- OVF_MODE 1 needs a 1-bit registered "just wrapped" flag, cleared on IDLE or RESYNC.

Optional Feature:
- Macro COUNTER_WRAP_MONITOR_CAPTURE_EN.
- Defined: adds outputs cap_expected (CNT_W) and cap_observed (CNT_W), loaded on the first err_seq after reset or clear and frozen until the next clear.
- Undefined: both ports exist and are tied to 0; no capture logic.

Decomposition:
- Shared package counter_mon_pkg:
  - state encoding constants MON_IDLE = 0, MON_TRACK = 1, MON_RESYNC = 2.
  - OVF_MODE values OVF_AT_MAX = 0, OVF_AFTER_WRAP = 1.
  - default widths.
- One natural sub-module: sat_counter (parameterised width, increment of 0/1/2, synchronous clear, saturation), used for err_count.

Test Plan:
- reset then cnt_reset pulse, enable = 1 for 40 cycles, legal counter, OVF_MODE 0 -> wrap_pulse at each 15 -> 0 step, epoch_out = 2 after 2 wraps, err_sticky = 0, err_count = 0.
- Counter stalls at 7 with enable = 1 (buggy counter) -> err_seq one cycle after the stuck sample, state_out = 2 for one cycle, then 1; err_count = 1; next legal step raises no error.
- overflow_in held low at count 15, OVF_MODE 0 -> err_ovf pulse only, no err_seq, epoch_out still increments.
- Jump 14 -> 0 plus overflow mismatch in the same sample -> err_seq and err_ovf both pulse, err_count + 2. Repeated faults drive err_count to 255 and it holds there.
- cnt_reset asserted mid-count at 9 -> state IDLE, no error flagged, epoch_out unchanged. clear asserted together with an error -> err_count = 0, err_sticky = 0.
- With COUNTER_WRAP_MONITOR_CAPTURE_EN, counter goes 3 -> 5 -> cap_expected = 4, cap_observed = 5. A second fault 6 -> 9 leaves the capture unchanged until clear.
